// File: rtl/spi_reg_pkg.sv
// Shared types and sizing helpers for the SPI register bank.
package spi_reg_pkg;

    typedef enum logic [1:0] {
        SYNC_WAIT,
        IDLE,
        SHIFT,
        CHECK
    } state_e;

    function automatic int frame_bits(input int aw, input int dw);
        return 1 + aw + dw;
    endfunction

    // The bit counter saturates at FRAME+1, so it must hold FRAME+1.
    function automatic int cnt_width(input int aw, input int dw);
        return $clog2(frame_bits(aw, dw) + 2);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, with a history flop for edge pulses.
module spi_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic hist_q, hist_d;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
        hist_d = sync_q;
    end

    // Reset low so that a chip select held low through reset never looks idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            hist_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~hist_q;
    assign fall  = ~sync_q & hist_q;

endmodule

// File: rtl/spi_reg_bank.sv
// Bank of NREGS x DW registers written and read back over SPI mode 0.
// All SPI pins are synchronised into clk; frames are W, ADDR, DATA, MSB first.
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int              NREGS     = 4,
    parameter int              AW        = 4,
    parameter int              DW        = 8,
    parameter logic [DW-1:0]   RESET_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  cs,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    output logic [NREGS*DW-1:0]   regs_out,
    output logic                  wr_strobe,
    output logic [AW-1:0]         wr_addr,
    output logic                  frame_err,
    output logic                  addr_err
);

    localparam int FRAME = frame_bits(AW, DW);
    localparam int CW    = cnt_width(AW, DW);
    localparam int SW    = (AW > DW) ? AW : DW;

    localparam logic [CW-1:0] CNT_HDR   = CW'(AW);
    localparam logic [CW-1:0] CNT_DATA  = CW'(AW + 1);
    localparam logic [CW-1:0] CNT_FRAME = CW'(FRAME);
    localparam logic [CW-1:0] CNT_SAT   = CW'(FRAME + 1);
    localparam logic [AW:0]   NREGS_LIM = (AW + 1)'(NREGS);

    logic sclk_lvl_unused, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge u_sync_sclk (
        .clk      (clk),
        .rst      (rst),
        .async_in (sclk),
        .level    (sclk_lvl_unused),
        .rise     (sclk_rise),
        .fall     (sclk_fall)
    );

    spi_sync_edge u_sync_cs (
        .clk      (clk),
        .rst      (rst),
        .async_in (cs),
        .level    (cs_lvl),
        .rise     (cs_rise),
        .fall     (cs_fall)
    );

    spi_sync_edge u_sync_mosi (
        .clk      (clk),
        .rst      (rst),
        .async_in (mosi),
        .level    (mosi_lvl),
        .rise     (mosi_rise_unused),
        .fall     (mosi_fall_unused)
    );

    state_e                     state_q, state_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [SW-1:0]              shift_q, shift_d;
    logic                       wr_bit_q, wr_bit_d;
    logic [AW-1:0]              addr_q, addr_d;
    logic [DW-1:0]              rd_q, rd_d;
    logic                       miso_q, miso_d;
    logic                       miso_oe_q, miso_oe_d;
    logic [NREGS-1:0][DW-1:0]   regs_q, regs_d;
    logic                       wr_strobe_q, wr_strobe_d;
    logic [AW-1:0]              wr_addr_q, wr_addr_d;
    logic                       frame_err_q, frame_err_d;
    logic                       addr_err_q, addr_err_d;

    logic [AW:0]                hdr;
    logic [DW-1:0]              rd_sel;
    logic                       hdr_valid;
    logic                       addr_valid;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        wr_bit_d    = wr_bit_q;
        addr_d      = addr_q;
        rd_d        = rd_q;
        miso_d      = miso_q;
        regs_d      = regs_q;
        wr_addr_d   = wr_addr_q;
        wr_strobe_d = 1'b0;
        frame_err_d = 1'b0;
        addr_err_d  = 1'b0;

        // Header as it will look once the current sclk rise is shifted in.
        hdr       = {shift_q[AW-1:0], mosi_lvl};
        hdr_valid = ({1'b0, hdr[AW-1:0]} < NREGS_LIM);
        rd_sel    = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (hdr[AW-1:0] == AW'(i)) rd_sel = regs_q[i];
        end
        addr_valid = ({1'b0, addr_q} < NREGS_LIM);

        unique case (state_q)
            SYNC_WAIT: begin
                if (cs_lvl) state_d = IDLE;
            end
            IDLE: begin
                if (cs_fall) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    shift_d = '0;
                    rd_d    = '0;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_d = CHECK;
                end else if (sclk_rise) begin
                    shift_d = {shift_q[SW-2:0], mosi_lvl};
                    if (cnt_q != CNT_SAT) cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CNT_HDR) begin
                        wr_bit_d = hdr[AW];
                        addr_d   = hdr[AW-1:0];
                        rd_d     = hdr_valid ? rd_sel : '0;
                        miso_d   = hdr_valid ? rd_sel[DW-1] : 1'b0;
                    end
                end else if (sclk_fall && (cnt_q > CNT_DATA)) begin
                    // The MSB was presented at the header edge; later falls advance it.
                    rd_d   = {rd_q[DW-2:0], 1'b0};
                    miso_d = rd_q[DW-2];
                end
            end
            CHECK: begin
                if (cnt_q != CNT_FRAME) begin
                    frame_err_d = 1'b1;
                end else if (!addr_valid) begin
                    addr_err_d = 1'b1;
                end else if (wr_bit_q) begin
                    for (int i = 0; i < NREGS; i++) begin
                        if (addr_q == AW'(i)) regs_d[i] = shift_q[DW-1:0];
                    end
                    wr_addr_d   = addr_q;
                    wr_strobe_d = 1'b1;
                end
                if (cs_fall) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    shift_d = '0;
                    rd_d    = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = SYNC_WAIT;
        endcase

        miso_oe_d = (state_d == SHIFT) && !cs_lvl;
        if (!miso_oe_d) miso_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SYNC_WAIT;
            cnt_q       <= '0;
            shift_q     <= '0;
            wr_bit_q    <= 1'b0;
            addr_q      <= '0;
            rd_q        <= '0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            regs_q      <= {NREGS{RESET_VAL}};
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            frame_err_q <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            wr_bit_q    <= wr_bit_d;
            addr_q      <= addr_d;
            rd_q        <= rd_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            regs_q      <= regs_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            frame_err_q <= frame_err_d;
            addr_err_q  <= addr_err_d;
        end
    end

    assign miso      = miso_q;
    assign miso_oe   = miso_oe_q;
    assign regs_out  = regs_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign frame_err = frame_err_q;
    assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed testbench for spi_reg_bank: drives SPI mode 0 frames at clk/10
// and compares registers, MISO read-back and status pulses with hand-computed values.
module tb_spi_reg_bank;

   localparam int NREGS = 4;
   localparam int AW    = 4;
   localparam int DW    = 8;

   logic                  clk;
   logic                  rst;
   logic                  sclk;
   logic                  cs;
   logic                  mosi;
   logic                  miso;
   logic                  miso_oe;
   logic [NREGS*DW-1:0]   regs_out;
   logic                  wr_strobe;
   logic [AW-1:0]         wr_addr;
   logic                  frame_err;
   logic                  addr_err;

   int assertCount = 0;
   int failCount   = 0;

   logic [7:0] dataMiso;
   logic       hdrMiso;
   logic       oeAll;
   int         strobeCnt;
   int         strobeCycle;
   int         frameErrCnt;
   int         addrErrCnt;

   spi_reg_bank #(
      .NREGS     (NREGS),
      .AW        (AW),
      .DW        (DW),
      .RESET_VAL (8'h00)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sclk      (sclk),
      .cs        (cs),
      .mosi      (mosi),
      .miso      (miso),
      .miso_oe   (miso_oe),
      .regs_out  (regs_out),
      .wr_strobe (wr_strobe),
      .wr_addr   (wr_addr),
      .frame_err (frame_err),
      .addr_err  (addr_err)
   );

   // 10 ns system clock; SCLK half period is five of these.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Drops cs and shifts nbits of 'bits' MSB first, leaving cs low.
   // Captures MISO just before each rising sclk edge, as a master would.
   task automatic applyStimulus(input int nbits, input logic [15:0] bits,
                                output logic [7:0] dataOut, output logic hdrOut, output logic oeOut);
      int k;
      dataOut = 8'h00;
      hdrOut  = 1'b0;
      oeOut   = 1'b1;
      @(negedge clk);
      cs = 1'b0;
      repeat (5) @(negedge clk);
      for (int i = nbits - 1; i >= 0; i--) begin
         k = nbits - 1 - i;
         mosi = bits[i];
         repeat (5) @(negedge clk);
         oeOut = oeOut & miso_oe;
         if (k < 1 + AW) hdrOut = hdrOut | miso;
         else if (k < 1 + AW + DW) dataOut[DW - 1 - (k - 1 - AW)] = miso;
         sclk = 1'b1;
         repeat (5) @(negedge clk);
         sclk = 1'b0;
      end
      mosi = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   // Raises cs and watches the next 8 clk cycles for the status pulses.
   task automatic finishFrame(output int sCnt, output int sCyc, output int fCnt, output int aCnt);
      sCnt = 0;
      sCyc = 0;
      fCnt = 0;
      aCnt = 0;
      cs = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk);
         #1;
         if (wr_strobe) begin
            sCnt++;
            if (sCyc == 0) sCyc = c;
         end
         if (frame_err) fCnt++;
         if (addr_err) aCnt++;
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      rst  = 1'b1;
      sclk = 1'b0;
      cs   = 1'b1;
      mosi = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);

      checkOutput("reset regs_out",  64'(regs_out),  64'h0);
      checkOutput("reset wr_strobe", 64'(wr_strobe), 64'h0);
      checkOutput("reset frame_err", 64'(frame_err), 64'h0);
      checkOutput("reset addr_err",  64'(addr_err),  64'h0);
      checkOutput("reset miso_oe",   64'(miso_oe),   64'h0);
      checkOutput("reset miso",      64'(miso),      64'h0);
      checkOutput("reset wr_addr",   64'(wr_addr),   64'h0);

      // W=1 ADDR=2 DATA=0xA5
      applyStimulus(13, 16'h12A5, dataMiso, hdrMiso, oeAll);
      checkOutput("wrA5 miso_oe during frame", 64'(oeAll), 64'h1);
      checkOutput("wrA5 miso old data", 64'(dataMiso), 64'h00);
      finishFrame(strobeCnt, strobeCycle, frameErrCnt, addrErrCnt);
      checkOutput("wrA5 strobe count", 64'(strobeCnt), 64'd1);
      checkOutput("wrA5 strobe cycle", 64'(strobeCycle), 64'd4);
      checkOutput("wrA5 frame_err", 64'(frameErrCnt), 64'd0);
      checkOutput("wrA5 addr_err", 64'(addrErrCnt), 64'd0);
      checkOutput("wrA5 regs_out", 64'(regs_out), 64'h00A5_0000);
      checkOutput("wrA5 wr_addr", 64'(wr_addr), 64'd2);
      checkOutput("wrA5 miso_oe after", 64'(miso_oe), 64'h0);

      // W=0 ADDR=2: read back 0xA5
      applyStimulus(13, 16'h0200, dataMiso, hdrMiso, oeAll);
      checkOutput("rd2 miso data", 64'(dataMiso), 64'hA5);
      checkOutput("rd2 miso header", 64'(hdrMiso), 64'h0);
      finishFrame(strobeCnt, strobeCycle, frameErrCnt, addrErrCnt);
      checkOutput("rd2 pulses", 64'(strobeCnt + frameErrCnt + addrErrCnt), 64'd0);
      checkOutput("rd2 regs_out", 64'(regs_out), 64'h00A5_0000);

      // W=1 ADDR=2 DATA=0x3C: MISO returns the previous 0xA5
      applyStimulus(13, 16'h123C, dataMiso, hdrMiso, oeAll);
      checkOutput("wr3C miso pre-frame", 64'(dataMiso), 64'hA5);
      finishFrame(strobeCnt, strobeCycle, frameErrCnt, addrErrCnt);
      checkOutput("wr3C strobe count", 64'(strobeCnt), 64'd1);
      checkOutput("wr3C regs_out", 64'(regs_out), 64'h003C_0000);

      // 12-bit frame, W=1 ADDR=1
      applyStimulus(12, 16'h08BB, dataMiso, hdrMiso, oeAll);
      finishFrame(strobeCnt, strobeCycle, frameErrCnt, addrErrCnt);
      checkOutput("short frame_err", 64'(frameErrCnt), 64'd1);
      checkOutput("short strobe", 64'(strobeCnt), 64'd0);
      checkOutput("short regs_out", 64'(regs_out), 64'h003C_0000);

      // 14-bit frame, W=1 ADDR=1
      applyStimulus(14, 16'h22EF, dataMiso, hdrMiso, oeAll);
      finishFrame(strobeCnt, strobeCycle, frameErrCnt, addrErrCnt);
      checkOutput("long frame_err", 64'(frameErrCnt), 64'd1);
      checkOutput("long strobe", 64'(strobeCnt), 64'd0);
      checkOutput("long regs_out", 64'(regs_out), 64'h003C_0000);

      // W=1 ADDR=5 DATA=0xFF: out of range
      applyStimulus(13, 16'h15FF, dataMiso, hdrMiso, oeAll);
      checkOutput("badaddr miso data", 64'(dataMiso), 64'h00);
      checkOutput("badaddr miso header", 64'(hdrMiso), 64'h0);
      finishFrame(strobeCnt, strobeCycle, frameErrCnt, addrErrCnt);
      checkOutput("badaddr addr_err", 64'(addrErrCnt), 64'd1);
      checkOutput("badaddr frame_err", 64'(frameErrCnt), 64'd0);
      checkOutput("badaddr strobe", 64'(strobeCnt), 64'd0);
      checkOutput("badaddr regs_out", 64'(regs_out), 64'h003C_0000);

      // Reset after 6 bits of a write to ADDR=0, then release cs
      applyStimulus(6, 16'h0020, dataMiso, hdrMiso, oeAll);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("midrst regs_out", 64'(regs_out), 64'h0);
      checkOutput("midrst miso_oe", 64'(miso_oe), 64'h0);
      finishFrame(strobeCnt, strobeCycle, frameErrCnt, addrErrCnt);
      checkOutput("midrst pulses", 64'(strobeCnt + frameErrCnt + addrErrCnt), 64'd0);
      repeat (3) @(negedge clk);

      // W=1 ADDR=0 DATA=0x11 after the aborted frame
      applyStimulus(13, 16'h1011, dataMiso, hdrMiso, oeAll);
      finishFrame(strobeCnt, strobeCycle, frameErrCnt, addrErrCnt);
      checkOutput("wr11 strobe count", 64'(strobeCnt), 64'd1);
      checkOutput("wr11 strobe cycle", 64'(strobeCycle), 64'd4);
      checkOutput("wr11 regs_out", 64'(regs_out), 64'h0000_0011);
      checkOutput("wr11 wr_addr", 64'(wr_addr), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/spi_reg_bank.md
Name: spi_reg_bank

Overview:
- Parametrised successor to the single 8-bit SPI latch: a bank of NREGS registers, each DW bits wide, written and read over SPI mode 0.
- The SPI pins are synchronised into the system clock domain, so all state lives on one clock. The old mixed SCLK/CS-edge logic is gone.
- Adds addressing, exact-length frame checking, read-back on MISO, a write strobe and error flags.
- Sits between the MCU SPI pins and the mux/peripheral-control logic in top; regs_out drives mux selects, LEDs and similar.

Parameters:
- NREGS, 4, number of registers (1..2**AW).
- AW, 4, address field width in bits.
- DW, 8, register width in bits (>=2).
- RESET_VAL, 0, value loaded into every register on reset (DW bits).

Ports:
- clk  in  1  system clock (XTALCLK); must be >= 8x SCLK frequency.
- rst  in  1  synchronous, active-high reset.
- sclk  in  1  SPI clock, asynchronous to clk.
- cs  in  1  SPI chip select, active low, asynchronous.
- mosi  in  1  SPI data in, asynchronous.
- miso  out  1  SPI data out.
- miso_oe  out  1  high while a frame is active (for an external tristate).
- regs_out  out  NREGS*DW  flattened registers; reg i is at [i*DW +: DW].
- wr_strobe  out  1  one-cycle pulse on a committed write.
- wr_addr  out  AW  address of the last committed write.
- frame_err  out  1  one-cycle pulse: bad frame length.
- addr_err  out  1  one-cycle pulse: address >= NREGS.

Behaviour:
- Sync: sclk, cs and mosi each pass through a 2-FF synchroniser, plus one history FF for edge detection. All logic is clocked on posedge clk.
- Frame layout, MSB first: W (1 bit, 1 = write), ADDR (AW bits), DATA (DW bits). FRAME = 1+AW+DW bits.
- MOSI is sampled on synchronised sclk rising edges. MISO changes on synchronised sclk falling edges.
- State machine:
  - IDLE: waiting for cs falling edge. Go to SHIFT, clear the bit counter and shift register.
  - SHIFT: each sclk rise shifts mosi in and increments the counter. The counter saturates at FRAME+1.
    - When counter reaches 1+AW: latch W and ADDR. Load the read shift register with regs[ADDR], or 0 if ADDR >= NREGS. Drive its MSB on miso.
    - Each subsequent sclk fall shifts the read register left.
    - On cs rise, go to CHECK.
  - CHECK (one cycle):
    - Counter != FRAME: pulse frame_err, no write.
    - Otherwise, if ADDR >= NREGS: pulse addr_err, no write.
    - Otherwise, if W=1: regs[ADDR] <= DATA, wr_addr <= ADDR, pulse wr_strobe.
    - If W=0: no state change.
    - Then go to IDLE.
  - SYNC_WAIT: entered after reset. Stays here until synchronised cs is high, then goes to IDLE. This prevents a half frame being accepted.
- Latency: from the cs rising edge at the pin, wr_strobe and the regs_out update appear 4 clk cycles later (2 sync + 1 edge + 1 CHECK). regs_out and wr_strobe change in the same cycle.
- Read-before-write: miso always returns the pre-frame contents of the addressed register.
- miso and miso_oe: miso = 0 while miso_oe is low, and during the W/ADDR phase. miso_oe = synchronised ~cs while in SHIFT.
- Simultaneous events:
  - sclk edges while in IDLE or CHECK are ignored.
  - A cs fall in the same cycle as CHECK is not lost: CHECK goes straight to SHIFT.
- Reset values: regs = RESET_VAL, miso = 0, miso_oe = 0, wr_strobe/frame_err/addr_err = 0, wr_addr = 0, state = SYNC_WAIT.
- Reset mid-frame: the frame is discarded. No strobe or error is raised for it.

Decomposition:
- Package spi_reg_pkg holds:
  - the state enum (SYNC_WAIT, IDLE, SHIFT, CHECK);
  - a FRAME localparam function of AW and DW;
  - the counter width $clog2(FRAME+2).
- Sub-module spi_sync_edge: a 2-FF synchroniser plus rise/fall pulse outputs. Instantiated three times, for sclk, cs and mosi (mosi uses only the level output).

Test Plan (NREGS=4, AW=4, DW=8, FRAME=13, SCLK = clk/10):
- Reset, then idle: regs_out=0x00000000, all pulses 0, miso_oe=0.
- Write frame W=1, ADDR=2, DATA=0xA5 -> regs_out[23:16]=0xA5, others 0. wr_strobe high exactly 1 cycle, 4 clk after cs rise. wr_addr=2.
- Read frame W=0, ADDR=2, DATA=0x00 -> miso shifts 1,0,1,0,0,1,0,1 on the data bits. regs_out unchanged. No pulses.
- Write to ADDR=2 with DATA=0x3C, immediately after the 0xA5 write -> miso returns 0xA5 during the frame; afterwards regs_out[23:16]=0x3C.
- 12-bit frame, then a 14-bit frame, both W=1 ADDR=1 -> frame_err pulses once per frame. regs_out[15:8] stays 0. No wr_strobe.
- W=1, ADDR=5, DATA=0xFF -> addr_err pulses, miso=0 throughout, regs unchanged.
- Assert rst after 6 bits of a write to ADDR=0, release, then raise cs -> no pulses. The next valid write of 0x11 to ADDR=0 commits normally.
